// File: rtl/hwag_pkg.sv
// Shared types and constants for the angle-generator family.
// Crank wheel generator FSM states and wheel geometry live here.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } cwg_state_t;

  localparam int TEETH_TOTAL   = 60;
  localparam int TEETH_MISSING = 2;
  localparam int TCNT_WIDTH    = 6;
  localparam int TCNT_TOP      = 57;
  localparam int PCNT_WIDTH    = 24;
  localparam int P_MIN         = 4;

endpackage

// File: rtl/cwg_phase_timer.sv
// Loadable down-counter timing one phase of the crank wheel waveform.
// Holds at zero until reloaded; zero flags the last cycle of a phase.
module cwg_phase_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_load,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = d_load;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/crank_wheel_gen.sv
// 60-2 crank wheel signal generator with programmable tooth period.
// state | meaning: IDLE stopped | HIGH tooth high | LOW tooth low | GAP missing teeth
module crank_wheel_gen #(
  parameter int                      PERIOD_WIDTH  = 24,
  parameter int                      TEETH_TOTAL   = 60,
  parameter int                      TEETH_MISSING = 2,
  parameter logic [PERIOD_WIDTH-1:0] PERIOD_RESET  = 24'd1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    period_wr,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  output logic                    cap,
  output logic [5:0]              tooth_num,
  output logic                    gap,
  output logic                    rev,
  output logic                    busy
);

  import hwag_pkg::*;

  localparam int TW = PERIOD_WIDTH + 2;
  localparam logic [5:0] TOOTH_TOP = 6'(TEETH_TOTAL - TEETH_MISSING - 1);
  localparam logic [PERIOD_WIDTH-1:0] PER_MIN = PERIOD_WIDTH'(P_MIN);

  cwg_state_t              state_q, state_d;
  logic [PERIOD_WIDTH-1:0] pend_q, pend_d, act_q, act_d, wr_val;
  logic [5:0]              tooth_q, tooth_d;
  logic                    cap_q, gap_q, rev_q, busy_q, rev_d;
  logic                    tmr_load, tmr_zero;
  logic [TW-1:0]           tmr_d_load, len_high_m1, len_low_m1, len_gap_m1;

  // pend_d is also the write-through value used when a write meets HIGH entry
  assign wr_val      = (period_in < PER_MIN) ? PER_MIN : period_in;
  assign pend_d      = period_wr ? wr_val : pend_q;
  assign len_high_m1 = TW'(pend_d >> 1) - TW'(1);
  assign len_low_m1  = TW'(act_q) - TW'(act_q >> 1) - TW'(1);
  assign len_gap_m1  = TW'(TEETH_MISSING) * TW'(act_q) - TW'(1);

  cwg_phase_timer #(.WIDTH(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .d_load (tmr_d_load),
    .zero   (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    tooth_d    = tooth_q;
    act_d      = act_q;
    rev_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_d_load = len_high_m1;
    unique case (state_q)
      IDLE: begin
        if (ena) begin
          state_d = HIGH;
          tooth_d = '0;
          rev_d   = 1'b1;
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          state_d    = LOW;
          tmr_load   = 1'b1;
          tmr_d_load = len_low_m1;
        end
      end
      LOW: begin
        if (tmr_zero) begin
          if (tooth_q == TOOTH_TOP) begin
            state_d    = GAP;
            tmr_load   = 1'b1;
            tmr_d_load = len_gap_m1;
          end else if (ena) begin
            state_d = HIGH;
            tooth_d = tooth_q + 6'd1;
          end else begin
            state_d = IDLE;
            tooth_d = '0;
          end
        end
      end
      GAP: begin
        if (tmr_zero) begin
          tooth_d = '0;
          if (ena) begin
            state_d = HIGH;
            rev_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // every HIGH entry latches the period so a tooth never changes shape midway
    if (state_d == HIGH && state_q != HIGH) begin
      act_d      = pend_d;
      tmr_load   = 1'b1;
      tmr_d_load = len_high_m1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= PERIOD_RESET;
      act_q   <= PERIOD_RESET;
      tooth_q <= '0;
      cap_q   <= 1'b0;
      gap_q   <= 1'b0;
      rev_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      tooth_q <= tooth_d;
      cap_q   <= (state_d == HIGH);
      gap_q   <= (state_d == GAP);
      rev_q   <= rev_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign cap       = cap_q;
  assign tooth_num = tooth_q;
  assign gap       = gap_q;
  assign rev       = rev_q;
  assign busy      = busy_q;

endmodule
